// File: rtl/jtkicker_colmix_multi.sv
// Priority layer mixer with per-channel palette PROMs and blanking realignment.
// Define JTKICKER_COLMIX_FADE_EN to add the frame-based fade in/out stage.
module jtkicker_colmix_multi #(
    parameter int unsigned     LAYERS    = 2,
    parameter int unsigned     PXLW      = 4,
    parameter int unsigned     PALW      = 4,
    parameter int unsigned     CW        = 4,
    parameter logic [PALW-1:0] BGPAL     = '1,
    parameter int unsigned     EXTRA_DLY = 0,
    parameter int unsigned     FADE_STEP = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   pxl_cen,
    input  logic                   LHBL,
    input  logic                   LVBL,
    input  logic [LAYERS*PXLW-1:0] lyr_pxl,
    input  logic [LAYERS*PALW-1:0] lyr_pal,
    input  logic [LAYERS*2-1:0]    prio,
    input  logic [LAYERS-1:0]      gfx_en,
    input  logic [PALW+PXLW-1:0]   prog_addr,
    input  logic [CW-1:0]          prog_data,
    input  logic [2:0]             prog_en,
    input  logic                   fade_req,
    input  logic                   fade_dir,
    output logic                   fade_busy,
    output logic [CW-1:0]          red,
    output logic [CW-1:0]          green,
    output logic [CW-1:0]          blue,
    output logic                   LHBL_dly,
    output logic                   LVBL_dly
);
    localparam int unsigned AW  = PALW + PXLW;
    localparam int unsigned LAT = 2 + EXTRA_DLY;

    logic [CW-1:0]   r_mem_r [2**AW];
    logic [CW-1:0]   r_mem_g [2**AW];
    logic [CW-1:0]   r_mem_b [2**AW];
    logic [AW-1:0]   r_addr;
    logic [3*CW-1:0] r_rd;
    logic [LAT-1:0]  r_hs;
    logic [LAT-1:0]  r_vs;
    logic [AW-1:0]   w_addr;
    logic [3*CW-1:0] w_col;
    logic            w_show;

    // Walk the priority list in order; the first opaque, enabled layer wins.
    always_comb begin
        logic w_found;
        w_found = 1'b0;
        w_addr  = {BGPAL, PXLW'(0)};
        for (int unsigned i = 0; i < LAYERS; i++) begin
            for (int unsigned j = 0; j < LAYERS; j++) begin
                if (!w_found && prio[i*2 +: 2] == 2'(j) && gfx_en[j] &&
                    lyr_pxl[j*PXLW +: PXLW] != '0) begin
                    w_found = 1'b1;
                    w_addr  = {lyr_pal[j*PALW +: PALW], lyr_pxl[j*PXLW +: PXLW]};
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_addr <= '0;
            r_hs   <= '0;
            r_vs   <= '0;
        end else if (pxl_cen) begin
            r_addr <= w_addr;
            r_hs   <= {r_hs[LAT-2:0], LHBL};
            r_vs   <= {r_vs[LAT-2:0], LVBL};
        end
    end

    // PROM arrays are never reset; a same-edge write leaves the read with old data.
    always_ff @(posedge clk) begin
        if (prog_en[0]) r_mem_r[prog_addr] <= prog_data;
        if (prog_en[1]) r_mem_g[prog_addr] <= prog_data;
        if (prog_en[2]) r_mem_b[prog_addr] <= prog_data;
        if (!rst_n) begin
            r_rd <= '0;
        end else if (pxl_cen) begin
            r_rd <= {r_mem_b[r_addr], r_mem_g[r_addr], r_mem_r[r_addr]};
        end
    end

    if (EXTRA_DLY > 0) begin : g_xdly
        logic [3*CW-1:0] r_xd [EXTRA_DLY];
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                for (int unsigned i = 0; i < EXTRA_DLY; i++) r_xd[i] <= '0;
            end else if (pxl_cen) begin
                r_xd[0] <= r_rd;
                for (int unsigned i = 1; i < EXTRA_DLY; i++) r_xd[i] <= r_xd[i-1];
            end
        end
        assign w_col = r_xd[EXTRA_DLY-1];
    end else begin : g_nodly
        assign w_col = r_rd;
    end

    assign LHBL_dly = r_hs[LAT-1];
    assign LVBL_dly = r_vs[LAT-1];
    assign w_show   = LHBL_dly & LVBL_dly;

`ifdef JTKICKER_COLMIX_FADE_EN
    typedef enum logic {IDLE, RUN} fade_state_t;
    localparam int unsigned CNTW = (FADE_STEP > 1) ? $clog2(FADE_STEP) : 1;

    fade_state_t     r_state;
    logic [4:0]      r_level;
    logic [CNTW-1:0] r_fcnt;
    logic            r_dir;
    logic            r_lvbl_q;
    logic            r_busy;
    logic            w_tick;
    logic            w_at_tgt;

    function automatic logic [CW-1:0] fade(input logic [CW-1:0] c, input logic [4:0] lvl);
        return CW'(((CW+5)'(c) * (CW+5)'(lvl)) >> 4);
    endfunction

    // A frame tick is the falling edge of the raw vertical blank.
    assign w_tick    = r_lvbl_q & ~LVBL;
    assign w_at_tgt  = r_dir ? (r_level == 5'd0) : (r_level == 5'd16);
    assign fade_busy = r_busy;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_level  <= 5'd16;
            r_fcnt   <= '0;
            r_dir    <= 1'b0;
            r_lvbl_q <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_lvbl_q <= LVBL;
            case (r_state)
                IDLE: begin
                    if (fade_req) begin
                        r_state <= RUN;
                        r_busy  <= 1'b1;
                        r_dir   <= fade_dir;
                        r_fcnt  <= '0;
                    end
                end
                RUN: begin
                    if (w_at_tgt) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end else if (w_tick) begin
                        if (r_fcnt == CNTW'(FADE_STEP - 1)) begin
                            r_fcnt  <= '0;
                            r_level <= r_dir ? r_level - 5'd1 : r_level + 5'd1;
                        end else begin
                            r_fcnt <= r_fcnt + CNTW'(1);
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_comb begin
        red   = '0;
        green = '0;
        blue  = '0;
        if (w_show) begin
            red   = fade(w_col[0    +: CW], r_level);
            green = fade(w_col[CW   +: CW], r_level);
            blue  = fade(w_col[2*CW +: CW], r_level);
        end
    end
`else
    logic w_unused;
    assign w_unused  = &{1'b0, fade_req, fade_dir, FADE_STEP != 0};
    assign fade_busy = 1'b0;

    always_comb begin
        red   = '0;
        green = '0;
        blue  = '0;
        if (w_show) begin
            red   = w_col[0    +: CW];
            green = w_col[CW   +: CW];
            blue  = w_col[2*CW +: CW];
        end
    end
`endif

endmodule

// File: tb/tb_jtkicker_colmix_multi.sv
// Bench for jtkicker_colmix_multi: two instances (EXTRA_DLY 0 and 3) against a PROM/priority model.
module tb_jtkicker_colmix_multi;
    logic       clk = 1'b0;
    logic       rst_n, pxl_cen, LHBL, LVBL;
    logic [7:0] lyr_pxl, lyr_pal, prog_addr;
    logic [3:0] prio, prog_data;
    logic [1:0] gfx_en;
    logic [2:0] prog_en;
    logic       fade_req, fade_dir;
    logic       busy0, busy3, hd0, hd3, vd0, vd3;
    logic [3:0] red0, green0, blue0, red3, green3, blue3;
    logic [13:0] act0, act3;

    int n_chk  = 0;
    int n_pass = 0;
    logic [3:0] m_prom [3][256];

    always #5 clk = ~clk;

    assign act0 = {red0, green0, blue0, hd0, vd0};
    assign act3 = {red3, green3, blue3, hd3, vd3};

    jtkicker_colmix_multi dut (
        .clk(clk), .rst_n(rst_n), .pxl_cen(pxl_cen), .LHBL(LHBL), .LVBL(LVBL),
        .lyr_pxl(lyr_pxl), .lyr_pal(lyr_pal), .prio(prio), .gfx_en(gfx_en),
        .prog_addr(prog_addr), .prog_data(prog_data), .prog_en(prog_en),
        .fade_req(fade_req), .fade_dir(fade_dir), .fade_busy(busy0),
        .red(red0), .green(green0), .blue(blue0), .LHBL_dly(hd0), .LVBL_dly(vd0)
    );

    jtkicker_colmix_multi #(.EXTRA_DLY(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .pxl_cen(pxl_cen), .LHBL(LHBL), .LVBL(LVBL),
        .lyr_pxl(lyr_pxl), .lyr_pal(lyr_pal), .prio(prio), .gfx_en(gfx_en),
        .prog_addr(prog_addr), .prog_data(prog_data), .prog_en(prog_en),
        .fade_req(fade_req), .fade_dir(fade_dir), .fade_busy(busy3),
        .red(red3), .green(green3), .blue(blue3), .LHBL_dly(hd3), .LVBL_dly(vd3)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic prog(input logic [7:0] a, input logic [2:0] en, input logic [3:0] d);
        prog_addr = a;
        prog_data = d;
        prog_en   = en;
        step();
        prog_en = '0;
        for (int c = 0; c < 3; c++) if (en[c]) m_prom[c][a] = d;
    endtask

    // First listed layer that is enabled and non-zero wins; otherwise background bank F.
    function automatic logic [7:0] model_addr(input logic [7:0] px, input logic [7:0] pl,
                                              input logic [3:0] pr, input logic [1:0] en);
        int l;
        for (int i = 0; i < 2; i++) begin
            l = int'(pr[i*2 +: 2]);
            if (l < 2 && en[l] && px[l*4 +: 4] != 4'h0) return {pl[l*4 +: 4], px[l*4 +: 4]};
        end
        return 8'hF0;
    endfunction

    function automatic logic [13:0] model_out(input logic [7:0] px, input logic [7:0] pl,
                                              input logic [3:0] pr, input logic [1:0] en,
                                              input logic h, input logic v);
        logic [7:0] a;
        a = model_addr(px, pl, pr, en);
        if (h && v) return {m_prom[0][a], m_prom[1][a], m_prom[2][a], 2'b11};
        return {12'h000, h, v};
    endfunction

    task automatic do_reset();
        rst_n    = 1'b0;
        fade_req = 1'b0;
        pxl_cen  = 1'b1;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic set_pix(input logic [7:0] px, input logic [7:0] pl, input logic [3:0] pr,
                           input logic [1:0] en);
        lyr_pxl = px; lyr_pal = pl; prio = pr; gfx_en = en;
        LHBL = 1'b1; LVBL = 1'b1; pxl_cen = 1'b1;
    endtask

    task automatic frame();
        LVBL = 1'b0;
        repeat (3) step();
        LVBL = 1'b1;
        repeat (6) step();
    endtask

    task automatic load_proms();
        do_reset();
        for (int c = 0; c < 3; c++)
            for (int a = 0; a < 256; a++) prog(8'(a), 3'(1 << c), 4'($urandom));
    endtask

    task automatic test_reset();
        prog(8'hF0, 3'b001, 4'h7);
        set_pix(8'h00, 8'h00, 4'b0100, 2'b11);
        repeat (6) step();
        n_chk++; if (red0 !== 4'h7) $display("FAIL pre_reset_bg red got=%h exp=7", red0); else n_pass++;
        rst_n = 1'b0;
        step();
        n_chk++; if (act0 !== 14'h0) $display("FAIL reset_out0 got=%h exp=0", act0); else n_pass++;
        n_chk++; if (act3 !== 14'h0) $display("FAIL reset_out3 got=%h exp=0", act3); else n_pass++;
        n_chk++; if ({busy0, busy3} !== 2'b00) $display("FAIL reset_busy got=%b exp=00", {busy0, busy3}); else n_pass++;
        rst_n = 1'b1;
    endtask

    task automatic test_priority();
        prog(8'h23, 3'b001, 4'hA);
        prog(8'h15, 3'b001, 4'h4);
        set_pix(8'h03, 8'h12, 4'b0001, 2'b11);
        repeat (6) step();
        n_chk++; if (red0 !== 4'hA) $display("FAIL prio_l1_clear got=%h exp=A", red0); else n_pass++;
        n_chk++; if (red3 !== 4'hA) $display("FAIL prio_l1_clear_d3 got=%h exp=A", red3); else n_pass++;
        lyr_pxl = 8'h53;
        for (int k = 1; k <= 5; k++) begin
            step();
            n_chk++; if (red0 !== ((k >= 2) ? 4'h4 : 4'hA)) $display("FAIL latency2 k=%0d got=%h exp=%h", k, red0, (k >= 2) ? 4'h4 : 4'hA); else n_pass++;
            n_chk++; if (red3 !== ((k >= 5) ? 4'h4 : 4'hA)) $display("FAIL latency5 k=%0d got=%h exp=%h", k, red3, (k >= 5) ? 4'h4 : 4'hA); else n_pass++;
        end
        prio = 4'b0100;
        repeat (6) step();
        n_chk++; if (red0 !== 4'hA) $display("FAIL prio_swap got=%h exp=A", red0); else n_pass++;
        gfx_en = 2'b00;
        repeat (6) step();
        n_chk++; if (red0 !== 4'h7) $display("FAIL gfx_off_bg got=%h exp=7", red0); else n_pass++;
        gfx_en = 2'b11; prio = 4'b0000; lyr_pxl = 8'h50;
        repeat (6) step();
        n_chk++; if (red0 !== 4'h7) $display("FAIL missing_layer_bg got=%h exp=7", red0); else n_pass++;
        prio = 4'b0101; lyr_pxl = 8'h53;
        repeat (6) step();
        n_chk++; if (red0 !== 4'h4) $display("FAIL dup_prio got=%h exp=4", red0); else n_pass++;
    endtask

    task automatic test_blank();
        set_pix(8'h03, 8'h12, 4'b0100, 2'b11);
        repeat (6) step();
        LHBL = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            step();
            LHBL = 1'b1;
            n_chk++; if ({hd0, red0} !== {k != 2, (k == 2) ? 4'h0 : 4'hA}) $display("FAIL blank_d0 k=%0d got=%b/%h", k, hd0, red0); else n_pass++;
            n_chk++; if ({hd3, red3} !== {k != 5, (k == 5) ? 4'h0 : 4'hA}) $display("FAIL blank_d3 k=%0d got=%b/%h", k, hd3, red3); else n_pass++;
        end
    endtask

    task automatic test_rw_same();
        logic [11:0] old;
        logic [3:0]  d;
        set_pix(8'h03, 8'h12, 4'b0100, 2'b11);
        repeat (6) step();
        old = {m_prom[0][8'h23], m_prom[1][8'h23], m_prom[2][8'h23]};
        d = 4'($urandom);
        if (d == old[11:8]) d = ~d;
        prog(8'h23, 3'b111, d);
        n_chk++; if ({red0, green0, blue0} !== old) $display("FAIL rw_old got=%h exp=%h", {red0, green0, blue0}, old); else n_pass++;
        step();
        n_chk++; if ({red0, green0, blue0} !== {d, d, d}) $display("FAIL rw_new got=%h exp=%h", {red0, green0, blue0}, {d, d, d}); else n_pass++;
        repeat (3) step();
        n_chk++; if ({red3, green3, blue3} !== {d, d, d}) $display("FAIL rw_new_d3 got=%h exp=%h", {red3, green3, blue3}, {d, d, d}); else n_pass++;
    endtask

    task automatic test_stream(input int n);
        logic [13:0] hist[$];
        int last;
        do_reset();
        repeat (4) hist.push_back(14'h0);
        for (int c = 0; c < n; c++) begin
            lyr_pxl[3:0] = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom);
            lyr_pxl[7:4] = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom);
            lyr_pal = 8'($urandom);
            prio    = 4'($urandom);
            gfx_en  = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b11;
            LHBL    = ($urandom_range(0, 9) != 0);
            LVBL    = ($urandom_range(0, 19) != 0);
            pxl_cen = ($urandom_range(0, 3) != 0);
            if (pxl_cen) hist.push_back(model_out(lyr_pxl, lyr_pal, prio, gfx_en, LHBL, LVBL));
            step();
            last = hist.size() - 1;
            n_chk++; if (act0 !== hist[last-1]) $display("FAIL stream_d0 cyc=%0d got=%h exp=%h", c, act0, hist[last-1]); else n_pass++;
            n_chk++; if (act3 !== hist[last-4]) $display("FAIL stream_d3 cyc=%0d got=%h exp=%h", c, act3, hist[last-4]); else n_pass++;
        end
        pxl_cen = 1'b1;
    endtask

`ifdef JTKICKER_COLMIX_FADE_EN
    task automatic test_fade();
        int lvl;
        logic [3:0] ef;
        do_reset();
        prog(8'h23, 3'b001, 4'hF);
        set_pix(8'h03, 8'h12, 4'b0100, 2'b11);
        repeat (6) step();
        n_chk++; if (red0 !== 4'hF) $display("FAIL fade_pre got=%h exp=F", red0); else n_pass++;
        fade_dir = 1'b1; fade_req = 1'b1;
        step();
        fade_req = 1'b0;
        n_chk++; if (busy0 !== 1'b1) $display("FAIL fade_busy_rise got=%b exp=1", busy0); else n_pass++;
        for (int f = 1; f <= 34; f++) begin
            frame();
            if (f == 10) begin
                fade_dir = 1'b0; fade_req = 1'b1;
                step();
                fade_req = 1'b0;
            end
            lvl = (f / 2 >= 16) ? 0 : 16 - f / 2;
            ef  = 4'((15 * lvl) >> 4);
            n_chk++; if (red0 !== ef) $display("FAIL fade_out_d0 f=%0d got=%h exp=%h", f, red0, ef); else n_pass++;
            n_chk++; if (red3 !== ef) $display("FAIL fade_out_d3 f=%0d got=%h exp=%h", f, red3, ef); else n_pass++;
            n_chk++; if (busy0 !== (f < 32)) $display("FAIL fade_busy f=%0d got=%b exp=%b", f, busy0, f < 32); else n_pass++;
        end
        fade_dir = 1'b1; fade_req = 1'b1;
        step();
        fade_req = 1'b0;
        n_chk++; if (busy0 !== 1'b1) $display("FAIL at_target_busy got=%b exp=1", busy0); else n_pass++;
        step();
        n_chk++; if (busy0 !== 1'b0) $display("FAIL at_target_idle got=%b exp=0", busy0); else n_pass++;
        fade_dir = 1'b0; fade_req = 1'b1;
        step();
        fade_req = 1'b0;
        repeat (4) frame();
        n_chk++; if (red0 !== 4'h1) $display("FAIL fade_in_lvl2 got=%h exp=1", red0); else n_pass++;
        n_chk++; if (busy0 !== 1'b1) $display("FAIL fade_in_busy got=%b exp=1", busy0); else n_pass++;
        rst_n = 1'b0;
        step();
        n_chk++; if ({act0, act3, busy0, busy3} !== 30'h0) $display("FAIL fade_reset got=%h/%h/%b%b exp=0", act0, act3, busy0, busy3); else n_pass++;
        rst_n = 1'b1;
        repeat (6) step();
        n_chk++; if ({red0, red3} !== 8'hFF) $display("FAIL fade_reset_full got=%h/%h exp=F/F", red0, red3); else n_pass++;
    endtask
`else
    task automatic test_fade();
        do_reset();
        prog(8'h23, 3'b001, 4'hF);
        set_pix(8'h03, 8'h12, 4'b0100, 2'b11);
        fade_dir = 1'b1; fade_req = 1'b1;
        step();
        fade_req = 1'b0;
        repeat (4) frame();
        n_chk++; if ({busy0, busy3} !== 2'b00) $display("FAIL fade_off_busy got=%b%b exp=00", busy0, busy3); else n_pass++;
        n_chk++; if ({red0, red3} !== 8'hFF) $display("FAIL fade_off_pass got=%h/%h exp=F/F", red0, red3); else n_pass++;
    endtask
`endif

    initial begin
        rst_n = 1'b0; pxl_cen = 1'b1; LHBL = 1'b0; LVBL = 1'b0;
        lyr_pxl = '0; lyr_pal = '0; prio = '0; gfx_en = '0;
        prog_addr = '0; prog_data = '0; prog_en = '0;
        fade_req = 1'b0; fade_dir = 1'b0;
        load_proms();
        test_reset();
        test_priority();
        test_blank();
        test_rw_same();
        test_stream(400);
        test_fade();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
